// File: rtl/uart_pixel_rx_if.sv
// ---------------------------------------------------------------------------
// uart_pixel_rx_if
// Pixel stream handshake between the UART pixel receiver and the
// detector-start logic.
//   pixel       : FIFO head byte, meaningful only while pixel_valid = 1
//   pixel_valid : receiver has at least one byte buffered
//   pixel_ready : consumer takes the presented pixel this cycle
// master = producer (receiver), slave = consumer.
// ---------------------------------------------------------------------------
interface uart_pixel_rx_if;
    logic [7:0] pixel;
    logic       pixel_valid;
    logic       pixel_ready;

    modport master (
        output pixel,
        output pixel_valid,
        input  pixel_ready
    );

    modport slave (
        input  pixel,
        input  pixel_valid,
        output pixel_ready
    );
endinterface

// File: rtl/uart_pixel_rx.sv
// ---------------------------------------------------------------------------
// uart_pixel_rx
// Deserialises 8N1 UART bytes into grayscale pixels, buffers them in a small
// show-ahead FIFO, presents them on a valid/ready handshake, drives RTS flow
// control from FIFO occupancy and counts pixels per frame.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   uart_rx      raw serial input, idle high, asynchronous to clock
//   uart_rts     1 = more bytes can be accepted
//   pix          pixel handshake (master side): pixel, pixel_valid, pixel_ready
//   frame_start  one-cycle pulse after the first pop of a frame
//   frame_done   one-cycle pulse after the pop of the last pixel of a frame
//   pixel_count  pixels popped so far in the current frame
//   framing_err  one-cycle pulse when a stop bit samples low
//   overrun_err  one-cycle pulse when a received byte is dropped (FIFO full)
// ---------------------------------------------------------------------------
module uart_pixel_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8,
    parameter int RTS_MARGIN   = 3,
    parameter int FRAME_PIXELS = 19200
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  uart_rx,
    output logic                  uart_rts,
    uart_pixel_rx_if.master       pix,
    output logic                  frame_start,
    output logic                  frame_done,
    output logic [15:0]           pixel_count,
    output logic                  framing_err,
    output logic                  overrun_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [OCC_W-1:0] FULL_OCC   = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] RTS_LIMIT  = OCC_W'(FIFO_DEPTH - RTS_MARGIN);
    localparam logic [15:0]      LAST_PIXEL = 16'(FRAME_PIXELS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    logic             rx_meta;
    logic             rx_s;
    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occupancy;
    logic [OCC_W-1:0] occupancy_next;

    logic push;
    logic push_ok;
    logic pop;
    logic full;

    // Two-flop synchroniser; resets to the idle (high) line level so that
    // leaving reset never looks like a start bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM. The start bit is re-checked half a bit after the falling
    // edge, so every later sample at BIT_LAST lands in the middle of a bit.
    // After a bad stop bit the line must return high before a new start is
    // accepted, so a held break cannot produce a stream of garbage bytes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            framing_err <= 1'b0;
        end else begin
            framing_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            framing_err <= 1'b1;
                            state       <= WAIT_HIGH;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The byte is written into the FIFO on the very edge that samples a good
    // stop bit, so it is visible at the FIFO head one cycle later.
    assign push    = (state == STOP) && (bit_cnt == BIT_LAST) && rx_s;
    assign full    = (occupancy == FULL_OCC);
    assign pop     = pix.pixel_valid & pix.pixel_ready;
    assign push_ok = push & (~full | pop);

    assign pix.pixel_valid = (occupancy != '0);
    assign pix.pixel       = mem[rd_ptr];

    always_comb begin
        occupancy_next = occupancy;
        if (push_ok && !pop) begin
            occupancy_next = occupancy + 1'b1;
        end else if (!push_ok && pop) begin
            occupancy_next = occupancy - 1'b1;
        end
    end

    // FIFO storage, pointers, RTS and overrun reporting. RTS looks at the
    // next occupancy so it drops on the same edge that the threshold byte
    // is written.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            uart_rts    <= 1'b1;
            overrun_err <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= shift_reg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occupancy   <= occupancy_next;
            uart_rts    <= (occupancy_next < RTS_LIMIT);
            overrun_err <= push & full & ~pop;
        end
    end

    // Frame bookkeeping on every pop. With a one-pixel frame the first and
    // last pixel coincide, so start and done pulse together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pixel_count <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_start <= pop && (pixel_count == 16'd0);
            frame_done  <= pop && (pixel_count == LAST_PIXEL);
            if (pop) begin
                if (pixel_count == LAST_PIXEL) begin
                    pixel_count <= '0;
                end else begin
                    pixel_count <= pixel_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_pixel_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_pixel_rx
// Directed bench for uart_pixel_rx with CLKS_PER_BIT=16, FIFO_DEPTH=8,
// RTS_MARGIN=3, FRAME_PIXELS=4. A negedge monitor logs pops, pulses and RTS
// falls with a posedge cycle stamp; directed tests compare those logs with
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_uart_pixel_rx;

    localparam int CPB    = 16;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 3;
    localparam int FRAME  = 4;
    // Cycles from driving the stop bit to the first negedge where the pushed
    // byte (and any pulse raised on the push edge) is visible:
    // 2 synchroniser flops + 8 cycles to mid-stop-bit + 1 registered edge.
    localparam int LAT    = 11;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic        uart_rx = 1'b1;
    logic        uart_rts;
    logic        frame_start;
    logic        frame_done;
    logic [15:0] pixel_count;
    logic        framing_err;
    logic        overrun_err;

    uart_pixel_rx_if pix_if ();

    uart_pixel_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .RTS_MARGIN   (MARGIN),
        .FRAME_PIXELS (FRAME)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .uart_rx     (uart_rx),
        .uart_rts    (uart_rts),
        .pix         (pix_if),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .pixel_count (pixel_count),
        .framing_err (framing_err),
        .overrun_err (overrun_err)
    );

    always #5 clock = ~clock;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    int unsigned cyc        = 0;
    int unsigned pops_total = 0;
    int unsigned valid_hi   = 0;
    logic        prev_rts   = 1'b1;

    int unsigned pop_data[$];
    int unsigned pop_cyc[$];
    int unsigned pop_cnt[$];
    int unsigned fs_q[$];
    int unsigned fd_q[$];
    int unsigned fe_q[$];
    int unsigned ov_q[$];
    int unsigned rts_fall_q[$];
    int unsigned stop_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor samples just after the negedge so stimulus set on that negedge
    // has settled. Pulse entries record how many pops had happened by then.
    always @(negedge clock) begin
        #1;
        if (frame_start) fs_q.push_back(pops_total);
        if (frame_done)  fd_q.push_back(pops_total);
        if (framing_err) fe_q.push_back(cyc);
        if (overrun_err) ov_q.push_back(cyc);
        if (prev_rts && !uart_rts) rts_fall_q.push_back(cyc);
        prev_rts <= uart_rts;
        if (pix_if.pixel_valid) valid_hi <= valid_hi + 1;
        if (pix_if.pixel_valid && pix_if.pixel_ready) begin
            pop_data.push_back(32'(pix_if.pixel));
            pop_cyc.push_back(cyc);
            pop_cnt.push_back(32'(pixel_count));
            pops_total <= pops_total + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sends one 8N1 frame; must be called on a negedge, returns on one.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (CPB) @(negedge clock);
        end
        uart_rx = stop_bit;
        stop_q.push_back(cyc);
        repeat (CPB) @(negedge clock);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_flags"},
                    32'({uart_rts, pix_if.pixel_valid, frame_start, frame_done,
                         framing_err, overrun_err}),
                    32'b100000);
        checkOutput({tag, "_pixel"}, 32'(pix_if.pixel), 32'h0);
        checkOutput({tag, "_count"}, 32'(pixel_count), 32'h0);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset_n = 1'b0;
        uart_rx = 1'b1;
        repeat (4) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    initial begin
        int unsigned b_pop, b_stop, b_fe, b_ov, b_rts, b_vh, b_fs, b_fd;
        int unsigned mask;

        pix_if.pixel_ready = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkResetState("reset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        // Single byte with ready high: one-cycle valid, fixed latency.
        $display("[TB] single byte 0xA5");
        pix_if.pixel_ready = 1'b1;
        b_pop = pop_data.size(); b_stop = stop_q.size();
        b_fe = fe_q.size(); b_ov = ov_q.size(); b_vh = valid_hi;
        applyStimulus(8'hA5, 1'b1);
        repeat (20) @(negedge clock);
        checkOutput("a5_pops", pop_data.size() - b_pop, 1);
        checkOutput("a5_data", pop_data[b_pop], 32'hA5);
        checkOutput("a5_latency", pop_cyc[b_pop] - stop_q[b_stop], LAT);
        checkOutput("a5_valid_width", valid_hi - b_vh, 1);
        checkOutput("a5_errors", (fe_q.size() - b_fe) + (ov_q.size() - b_ov), 0);

        // Ten back-to-back bytes into a stalled consumer.
        $display("[TB] fill and overrun");
        pix_if.pixel_ready = 1'b0;
        b_pop = pop_data.size(); b_stop = stop_q.size();
        b_ov = ov_q.size(); b_rts = rts_fall_q.size();
        for (int i = 1; i <= 10; i++) applyStimulus(8'(i), 1'b1);
        repeat (20) @(negedge clock);
        checkOutput("fill_rts_falls", rts_fall_q.size() - b_rts, 1);
        checkOutput("fill_rts_cycle", rts_fall_q[b_rts], stop_q[b_stop + 4] + LAT);
        checkOutput("fill_rts_low", 32'(uart_rts), 0);
        checkOutput("fill_head", 32'(pix_if.pixel), 32'h01);
        checkOutput("fill_overruns", ov_q.size() - b_ov, 2);
        checkOutput("fill_ov9_cycle", ov_q[b_ov], stop_q[b_stop + 8] + LAT);
        checkOutput("fill_ov10_cycle", ov_q[b_ov + 1], stop_q[b_stop + 9] + LAT);
        pix_if.pixel_ready = 1'b1;
        repeat (12) @(negedge clock);
        checkOutput("drain_pops", pop_data.size() - b_pop, 8);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("drain_data%0d", i), pop_data[b_pop + i], 32'(i + 1));
        checkOutput("drain_empty", 32'(pix_if.pixel_valid), 0);
        checkOutput("drain_rts", 32'(uart_rts), 1);

        // Short low glitch must not start a byte.
        $display("[TB] start-bit glitch");
        b_pop = pop_data.size(); b_fe = fe_q.size();
        uart_rx = 1'b0;
        repeat (4) @(negedge clock);
        uart_rx = 1'b1;
        repeat (40) @(negedge clock);
        checkOutput("glitch_pops", pop_data.size() - b_pop, 0);
        checkOutput("glitch_fe", fe_q.size() - b_fe, 0);
        applyStimulus(8'h5A, 1'b1);
        repeat (20) @(negedge clock);
        checkOutput("glitch_next", pop_data[b_pop], 32'h5A);

        // Bad stop bit followed by a held break, then a good byte.
        $display("[TB] framing error");
        b_pop = pop_data.size(); b_stop = stop_q.size(); b_fe = fe_q.size();
        applyStimulus(8'h3C, 1'b0);
        repeat (40) @(negedge clock);
        uart_rx = 1'b1;
        repeat (20) @(negedge clock);
        applyStimulus(8'h55, 1'b1);
        repeat (20) @(negedge clock);
        checkOutput("fe_count", fe_q.size() - b_fe, 1);
        checkOutput("fe_cycle", fe_q[b_fe], stop_q[b_stop] + LAT);
        checkOutput("fe_pops", pop_data.size() - b_pop, 1);
        checkOutput("fe_data", pop_data[b_pop], 32'h55);

        // Frame boundaries with four-pixel frames.
        $display("[TB] frame counting");
        doReset();
        pix_if.pixel_ready = 1'b1;
        b_pop = pop_data.size(); b_fs = fs_q.size(); b_fd = fd_q.size();
        for (int i = 0; i < 9; i++) applyStimulus(8'(8'h30 + i), 1'b1);
        repeat (20) @(negedge clock);
        mask = 0;
        for (int i = b_fs; i < fs_q.size(); i++) mask |= 32'd1 << (fs_q[i] - b_pop);
        checkOutput("frame_start_pops", mask, 32'h222);
        mask = 0;
        for (int i = b_fd; i < fd_q.size(); i++) mask |= 32'd1 << (fd_q[i] - b_pop);
        checkOutput("frame_done_pops", mask, 32'h110);
        checkOutput("frame_count_end", 32'(pixel_count), 1);
        checkOutput("frame_last_data", pop_data[b_pop + 8], 32'h38);

        // Reset in the middle of a byte with two bytes queued.
        $display("[TB] reset mid-byte");
        doReset();
        pix_if.pixel_ready = 1'b0;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        repeat (4) @(negedge clock);
        checkOutput("queued_head", 32'(pix_if.pixel), 32'h11);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        uart_rx = 1'b1;
        repeat (3 * CPB + 5) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkResetState("midreset");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        pix_if.pixel_ready = 1'b1;
        b_pop = pop_data.size();
        applyStimulus(8'h81, 1'b1);
        repeat (20) @(negedge clock);
        checkOutput("after_reset_pops", pop_data.size() - b_pop, 1);
        checkOutput("after_reset_data", pop_data[b_pop], 32'h81);
        checkOutput("after_reset_count", pop_cnt[b_pop], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
